keypad_matrix_scan: RTL and testbench

KEYPAD_MATRIX_SCAN -- requirements
Module: keypad_matrix_scan

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_evt_fifo.sv | 55 +++++
 rtl/keypad_matrix_scan.sv | 162 ++++++++++++++++
 tb/tb_keypad_matrix_scan.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, event record and code-width helper for the keypad scanner.
// Consumed by keypad_matrix_scan and keypad_evt_fifo.
package keypad_pkg;

    localparam int DEF_ROWS           = 4;
    localparam int DEF_COLS           = 4;
    localparam int DEF_SCAN_DIV       = 60000;
    localparam int DEF_DEBOUNCE_SCANS = 4;
    localparam int DEF_FIFO_DEPTH     = 8;

    // Event code field is sized for the largest matrix (16x16 keys).
    localparam int EVT_CW = 8;
    localparam int DEB_W  = 4;

    typedef struct packed {
        logic [EVT_CW-1:0] code;
        logic              press;
    } evt_t;

    function automatic int code_w(input int n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Keypad event FIFO: power-of-two depth, registered occupancy.
// Full is taken from the registered count, so a same-cycle pop never frees a slot.
module keypad_evt_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic push_in,
    input  evt_t din,
    output logic full_out,
    input  logic ready_in,
    output logic valid_out,
    output evt_t dout
);

    localparam int AW = $clog2(DEPTH);

    evt_t          r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_wr;
    logic          w_rd;

    assign full_out  = (r_cnt == (AW+1)'(DEPTH));
    assign valid_out = (r_cnt != '0);
    assign dout      = r_mem[r_rp];
    assign w_wr      = push_in && !full_out;
    assign w_rd      = valid_out && ready_in;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage array; contents are don't-care while unoccupied.
    always_ff @(posedge clk_in) begin
        if (w_wr) r_mem[r_wp] <= din;
    end

endmodule

// File: rtl/keypad_matrix_scan.sv
// Row-scanned keypad matrix with per-key debounce and a press/release event queue.
// Define KEYPAD_EVENT_FIFO_EN for a FIFO_DEPTH-entry buffer; default is one holding register.
module keypad_matrix_scan
    import keypad_pkg::*;
#(
    parameter int ROWS           = DEF_ROWS,
    parameter int COLS           = DEF_COLS,
    parameter int SCAN_DIV       = DEF_SCAN_DIV,
    parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [COLS-1:0]                    col_in,
    output logic [ROWS-1:0]                    row_out,
    output logic [ROWS*COLS-1:0]               key_state,
    output logic                               evt_valid,
    input  logic                               evt_ready,
    output logic [code_w(ROWS*COLS)-1:0]       evt_code,
    output logic                               evt_press
);

    localparam int NK  = ROWS * COLS;
    localparam int CW  = code_w(NK);
    localparam int RW  = code_w(ROWS);
    localparam int DW  = $clog2(SCAN_DIV);
    localparam logic [DEB_W-1:0] DEB = DEB_W'(DEBOUNCE_SCANS);

    logic [DW-1:0]    r_div;
    logic [RW-1:0]    r_row;
    logic [COLS-1:0]  r_sync1;
    logic [COLS-1:0]  r_sync2;
    logic [DEB_W-1:0] r_cnt     [NK];
    logic [DEB_W-1:0] w_cnt_nxt [NK];
    logic             w_wrap;
    logic [COLS-1:0]  w_samp;
    logic             w_hit;
    logic [NK-1:0]    w_toggle;
    evt_t             w_evt;
    evt_t             w_out;
    logic             w_full;
    logic             w_valid;
    logic             w_unused;

    assign w_wrap    = (r_div == DW'(SCAN_DIV - 1));
    assign w_samp    = ~r_sync2;
    assign evt_valid = w_valid;
    assign evt_code  = w_out.code[CW-1:0];
    assign evt_press = w_out.press;
    assign w_unused  = &{1'b0, w_out.code, FIFO_DEPTH[0]};

    // Dwell counter and row pointer; the row advances on the dwell wrap.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_div <= '0;
            r_row <= '0;
        end else if (w_wrap) begin
            r_div <= '0;
            r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // One-cold row drive decoded from the row pointer.
    always_comb begin
        row_out = '1;
        for (int r = 0; r < ROWS; r++) begin
            row_out[r] = (r_row != RW'(r));
        end
    end

    // Two-flop synchroniser on the raw, pulled-up columns.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= col_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce update for the sampled row and lowest-column commit selection.
    always_comb begin
        w_hit    = 1'b0;
        w_toggle = '0;
        w_evt    = '0;
        for (int k = 0; k < NK; k++) begin
            w_cnt_nxt[k] = r_cnt[k];
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (w_wrap && (r_row == RW'(r))) begin
                    if (w_samp[c] == key_state[r*COLS+c]) begin
                        w_cnt_nxt[r*COLS+c] = '0;
                    end else if (r_cnt[r*COLS+c] != DEB) begin
                        w_cnt_nxt[r*COLS+c] = r_cnt[r*COLS+c] + 1'b1;
                    end
                    if ((w_cnt_nxt[r*COLS+c] == DEB) && !w_hit && !w_full) begin
                        w_hit                = 1'b1;
                        w_toggle[r*COLS+c]   = 1'b1;
                        w_cnt_nxt[r*COLS+c]  = '0;
                        w_evt.code           = EVT_CW'(r*COLS+c);
                        w_evt.press          = w_samp[c];
                    end
                end
            end
        end
    end

    // Debounce counters and the committed key map.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            key_state <= '0;
            for (int k = 0; k < NK; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            key_state <= key_state ^ w_toggle;
            for (int k = 0; k < NK; k++) begin
                r_cnt[k] <= w_cnt_nxt[k];
            end
        end
    end

`ifdef KEYPAD_EVENT_FIFO_EN
    keypad_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push_in   (w_hit),
        .din       (w_evt),
        .full_out  (w_full),
        .ready_in  (evt_ready),
        .valid_out (w_valid),
        .dout      (w_out)
    );
`else
    logic r_hvalid;
    evt_t r_hold;

    assign w_full  = r_hvalid;
    assign w_valid = r_hvalid;
    assign w_out   = r_hold;

    // Single holding register: a push only happens while it is empty.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_hvalid <= 1'b0;
            r_hold   <= '0;
        end else if (w_hit) begin
            r_hvalid <= 1'b1;
            r_hold   <= w_evt;
        end else if (evt_ready) begin
            r_hvalid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Scoreboard bench for keypad_matrix_scan (4x4, SCAN_DIV=8, DEBOUNCE_SCANS=3, FIFO_DEPTH=2).
// Stimulus pushes expected events; a negedge monitor pops and compares on each transfer.
module tb_keypad_matrix_scan;

`ifdef KEYPAD_EVENT_FIFO_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam int FRAME = 32;

    logic        clk;
    logic        rst;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] key_state;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_code;
    logic        evt_press;
    logic [15:0] pressed;

    int n_tests = 0;
    int n_fail  = 0;
    int sb_q[$];
    bit prev_hold = 0;
    int prev_code = 0;
    bit prev_press = 0;

    keypad_matrix_scan #(
        .ROWS           (4),
        .COLS           (4),
        .SCAN_DIV       (8),
        .DEBOUNCE_SCANS (3),
        .FIFO_DEPTH     (2)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_state (key_state),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_press (evt_press)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Pressed key shorts its column low while its row is driven low.
    always_comb begin
        col_in = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_evt(input int code, input bit press);
        sb_q.push_back(code * 2 + int'(press));
    endtask

    // Monitor: pop and compare on every transfer; check hold stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", int'(evt_valid), 1);
                check("hold_code", int'(evt_code), prev_code);
                check("hold_press", int'(evt_press), int'(prev_press));
            end
            if (evt_valid && evt_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_evt: got code %0d press %0d expected none",
                             evt_code, evt_press);
                end else begin
                    int e;
                    e = sb_q.pop_front();
                    check("evt_code", int'(evt_code), e / 2);
                    check("evt_press", int'(evt_press), e % 2);
                end
            end
            prev_hold  = evt_valid && !evt_ready;
            prev_code  = int'(evt_code);
            prev_press = evt_press;
        end
    end

    initial begin
        rst       = 1;
        pressed   = '0;
        evt_ready = 1;
        cyc(3);
        check("rst_row", int'(row_out), 4'b1110);
        check("rst_keys", int'(key_state), 0);
        check("rst_valid", int'(evt_valid), 0);

        // Scan stepping: row changes on the 8th edge after release.
        rst = 0;
        cyc(4);
        check("scan_r0", int'(row_out), 4'b1110);
        cyc(8);
        check("scan_r1", int'(row_out), 4'b1101);
        cyc(8);
        check("scan_r2", int'(row_out), 4'b1011);
        cyc(8);
        check("scan_r3", int'(row_out), 4'b0111);
        cyc(8);
        check("scan_wrap", int'(row_out), 4'b1110);

        // Debounced press then release of row2/col1.
        pressed[9] = 1;
        expect_evt(9, 1);
        cyc(4 * FRAME);
        check("deb_press_state", int'(key_state), 16'h0200);
        pressed[9] = 0;
        expect_evt(9, 0);
        cyc(4 * FRAME);
        check("deb_rel_state", int'(key_state), 0);
        check("deb_drained", sb_q.size(), 0);

        // Bounce: exactly two samples of a press, then release.
        pressed[5] = 1;
        cyc(2 * FRAME);
        pressed[5] = 0;
        cyc(4 * FRAME);
        check("bounce_state", int'(key_state), 0);

        // Same-row conflict: col0 commits before col3.
        pressed[4] = 1;
        pressed[7] = 1;
        expect_evt(4, 1);
        expect_evt(7, 1);
        cyc(5 * FRAME);
        check("conf_state", int'(key_state), 16'h0090);
        pressed[4] = 0;
        pressed[7] = 0;
        expect_evt(4, 0);
        expect_evt(7, 0);
        cyc(5 * FRAME);
        check("conf_rel_state", int'(key_state), 0);
        check("conf_drained", sb_q.size(), 0);

        // Backpressure: staggered presses with the consumer stalled.
        evt_ready = 0;
        pressed[1] = 1;
        expect_evt(1, 1);
        cyc(FRAME);
        pressed[6] = 1;
        expect_evt(6, 1);
        cyc(FRAME);
        pressed[11] = 1;
        expect_evt(11, 1);
        cyc(4 * FRAME);
        check("bp_state", int'(key_state), (CAP == 2) ? 16'h0042 : 16'h0002);
        check("bp_valid", int'(evt_valid), 1);
        check("bp_head", int'(evt_code), 1);
        evt_ready = 1;
        cyc(4 * FRAME);
        check("bp_all_state", int'(key_state), 16'h0842);
        check("bp_drained", sb_q.size(), 0);
        pressed[1] = 0;
        expect_evt(1, 0);
        cyc(FRAME);
        pressed[6] = 0;
        expect_evt(6, 0);
        cyc(FRAME);
        pressed[11] = 0;
        expect_evt(11, 0);
        cyc(4 * FRAME);
        check("bp_rel_state", int'(key_state), 0);

        // Reset mid-operation discards the pending event; held key re-presses.
        evt_ready = 0;
        pressed[14] = 1;
        expect_evt(14, 1);
        cyc(4 * FRAME);
        check("mid_pending", int'(evt_valid), 1);
        rst = 1;
        sb_q.delete();
        cyc(2);
        check("mid_rst_keys", int'(key_state), 0);
        check("mid_rst_valid", int'(evt_valid), 0);
        check("mid_rst_row", int'(row_out), 4'b1110);
        rst = 0;
        evt_ready = 1;
        expect_evt(14, 1);
        cyc(4 * FRAME);
        check("mid_repress", int'(key_state), 16'h4000);
        pressed[14] = 0;
        expect_evt(14, 0);
        cyc(4 * FRAME);
        check("final_state", int'(key_state), 0);
        check("final_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
